window_scan_ctrl: RTL
=====================

WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 45, maximum scaled image width in pixels.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 45, maximum scaled image height in pixels.
REQ-003 The block SHALL have parameter W_SCALE, default 4, width of the scale index.
REQ-004 The block SHALL have parameter WIN_SIZE, default 24, square detection window side in pixels.
REQ-005 The block SHALL have parameter STEP, default 1, window stride in pixels (>=1), identical in x and y.
REQ-006 The block SHALL derive W_X = $clog2(IMG_WIDTH) and W_Y = $clog2(IMG_HEIGHT).
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have port start, input, 1 bit: frame start request, sampled in IDLE only.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-012 The block SHALL have ports scale_desc_valid (input, 1), scale_desc_ready (output, 1), scale_desc_w (input, W_X), scale_desc_h (input, W_Y) and scale_desc_last (input, 1): per-scale image size stream.
REQ-013 The block SHALL have ports window_pos_valid (output, 1), window_pos_ready (input, 1), window_pos_eot (output, 1), window_pos_scale (output, W_SCALE), window_pos_x (output, W_X) and window_pos_y (output, W_Y): window position stream.

Function
REQ-014 The block SHALL implement states IDLE, LOAD, SCAN and DONE.
REQ-015 IDLE SHALL go to LOAD on the cycle after start=1; it SHALL clear the scale index to 0 on that transition.
REQ-016 In LOAD, scale_desc_ready SHALL be 1 (it SHALL be 0 in all other states); on a valid&ready handshake the block SHALL latch w, h and last.
REQ-017 If the accepted descriptor has w>=WIN_SIZE and h>=WIN_SIZE, the block SHALL enter SCAN with x=0 and y=0.
REQ-018 If the accepted descriptor is undersized, the block SHALL skip it: go to DONE if last, otherwise stay in LOAD, incrementing the scale index in both cases.
REQ-019 In SCAN, window_pos_valid SHALL be 1, and x, y, scale and eot SHALL be held stable while valid is high and window_pos_ready is low.
REQ-020 Scan order SHALL be x fastest, then y; x_max = largest multiple of STEP <= w-WIN_SIZE, and y_max likewise from h.
REQ-021 On a handshake with x<x_max, the block SHALL apply x+=STEP; at x=x_max with y<y_max, it SHALL set x=0 and y+=STEP.
REQ-022 On a handshake at x=x_max and y=y_max, the block SHALL increment the scale index (wrapping at 2^W_SCALE) and go to DONE if last, otherwise to LOAD.
REQ-023 window_pos_eot SHALL be 1 only on the position x=x_max, y=y_max of a descriptor with last=1.
REQ-024 A frame in which every descriptor is skipped SHALL emit no positions and no eot, but SHALL still pulse done.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 Throughput SHALL be one position per cycle when window_pos_ready is held high, with one LOAD cycle (minimum) between scales.
REQ-028 Arithmetic SHALL be performed at W_X/W_Y+1 bits so that x+STEP and w-WIN_SIZE do not overflow.

Reset
REQ-029 rst=1 SHALL force IDLE and set busy=0, done=0, scale_desc_ready=0, window_pos_valid=0, window_pos_eot=0, and x, y, scale=0 on the next edge.
REQ-030 Reset mid-frame SHALL abandon the frame with no done pulse; descriptors already accepted SHALL NOT be replayed.

Configuration
REQ-031 With macro WINDOW_SCAN_CTRL_WIN_COUNT_EN defined, the block SHALL add output win_count (32 bits), counting window_pos handshakes in the current frame, cleared on reset and on the IDLE->LOAD transition, and holding its value after done.
REQ-032 Without WINDOW_SCAN_CTRL_WIN_COUNT_EN, the block SHALL have no win_count port and no counter logic.

Verification
REQ-033 One 24x24 descriptor with last=1 and ready tied high -> exactly one position (0,0), scale 0, eot=1, with done 2 cycles after the handshake.
REQ-034 A 45x45 descriptor with last=1 and STEP=1 -> 484 positions in raster order, eot only at (21,21), and win_count=484 when the macro is enabled.
REQ-035 Descriptors 45x45, 30x30 and 24x24 (last) with STEP=2 -> 121+16+1 positions with scales 0,1,2, and eot only on the final position.
REQ-036 Random window_pos_ready backpressure -> outputs stable while stalled, with no positions dropped or duplicated against a reference model.
REQ-037 Descriptors 20x45 then 24x24 (last) -> the first is skipped, the single position carries scale=1 with eot; an all-undersized frame -> done pulse with no positions.
REQ-038 rst asserted mid-SCAN, then start -> valid low the next cycle, and the new frame begins at (0,0) with scale 0.

Source files
------------

// File: rtl/window_scan_ctrl.sv
// Sliding-window position generator: walks a WIN_SIZE window over each scaled image size
// descriptor in raster order. Optional macro WINDOW_SCAN_CTRL_WIN_COUNT_EN adds a per-frame window counter.
module window_scan_ctrl #(
  parameter int IMG_WIDTH  = 45,
  parameter int IMG_HEIGHT = 45,
  parameter int W_SCALE    = 4,
  parameter int WIN_SIZE   = 24,
  parameter int STEP       = 1,
  localparam int W_X       = $clog2(IMG_WIDTH),
  localparam int W_Y       = $clog2(IMG_HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               scale_desc_valid,
  output logic               scale_desc_ready,
  input  logic [W_X-1:0]     scale_desc_w,
  input  logic [W_Y-1:0]     scale_desc_h,
  input  logic               scale_desc_last,
`ifdef WINDOW_SCAN_CTRL_WIN_COUNT_EN
  output logic [31:0]        win_count,
`endif
  output logic               window_pos_valid,
  input  logic               window_pos_ready,
  output logic               window_pos_eot,
  output logic [W_SCALE-1:0] window_pos_scale,
  output logic [W_X-1:0]     window_pos_x,
  output logic [W_Y-1:0]     window_pos_y
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

  localparam logic [W_X:0] WIN_X  = (W_X+1)'(WIN_SIZE);
  localparam logic [W_Y:0] WIN_Y  = (W_Y+1)'(WIN_SIZE);
  localparam logic [W_X:0] STEP_X = (W_X+1)'(STEP);
  localparam logic [W_Y:0] STEP_Y = (W_Y+1)'(STEP);

  state_t               state_q, state_d;
  logic [W_SCALE-1:0]   scale_q, scale_d;
  logic [W_X-1:0]       x_q, x_d;
  logic [W_Y-1:0]       y_q, y_d;
  logic [W_X-1:0]       w_q, w_d;
  logic [W_Y-1:0]       h_q, h_d;
  logic                 last_q, last_d;

  logic [W_X:0]         x_ext, diff_x, x_max;
  logic [W_Y:0]         y_ext, diff_y, y_max;
  logic                 at_x_end, at_y_end, desc_fits, pos_hs;

  // Last legal origin is the largest stride multiple not exceeding size-WIN_SIZE.
  always_comb begin
    x_ext    = {1'b0, x_q};
    y_ext    = {1'b0, y_q};
    diff_x   = {1'b0, w_q} - WIN_X;
    diff_y   = {1'b0, h_q} - WIN_Y;
    x_max    = diff_x - (diff_x % STEP_X);
    y_max    = diff_y - (diff_y % STEP_Y);
    at_x_end = (x_ext >= x_max);
    at_y_end = (y_ext >= y_max);
    desc_fits = ({1'b0, scale_desc_w} >= WIN_X) && ({1'b0, scale_desc_h} >= WIN_Y);
    pos_hs   = (state_q == S_SCAN) && window_pos_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      scale_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scale_q <= scale_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scale_d = scale_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          scale_d = '0;
        end
      end
      S_LOAD: begin
        if (scale_desc_valid) begin
          w_d    = scale_desc_w;
          h_d    = scale_desc_h;
          last_d = scale_desc_last;
          if (desc_fits) begin
            state_d = S_SCAN;
            x_d     = '0;
            y_d     = '0;
          end else begin
            // Undersized scale: consume its index without emitting anything.
            scale_d = scale_q + 1'b1;
            state_d = scale_desc_last ? S_DONE : S_LOAD;
          end
        end
      end
      S_SCAN: begin
        if (window_pos_ready) begin
          if (!at_x_end) begin
            x_d = W_X'(x_ext + STEP_X);
          end else if (!at_y_end) begin
            x_d = '0;
            y_d = W_Y'(y_ext + STEP_Y);
          end else begin
            scale_d = scale_q + 1'b1;
            state_d = last_q ? S_DONE : S_LOAD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q != S_IDLE);
    done             = (state_q == S_DONE);
    scale_desc_ready = (state_q == S_LOAD);
    window_pos_valid = (state_q == S_SCAN);
    window_pos_eot   = (state_q == S_SCAN) && last_q && at_x_end && at_y_end;
    window_pos_scale = scale_q;
    window_pos_x     = x_q;
    window_pos_y     = y_q;
  end

`ifdef WINDOW_SCAN_CTRL_WIN_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_IDLE) && start) begin
      cnt_d = '0;
    end else if (pos_hs) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign win_count = cnt_q;
`else
  logic unused_hs;
  assign unused_hs = pos_hs;
`endif

endmodule
